// File: rtl/seg_display_arbiter.sv
// Four-source arbiter for a shared 4-digit BCD display with a minimum dwell per owner.
// Build option: define SEG_ARB_ROUNDROBIN_EN for round-robin; default is fixed priority (lowest index).
module seg_display_arbiter #(
    parameter int unsigned DWELL_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [63:0] data,
    output logic [3:0]  grant,
    output logic [1:0]  owner_id,
    output logic [15:0] number,
    output logic        disp_en
);

    localparam logic [15:0] DWELL = 16'(DWELL_CYCLES);

    typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  owner_q, owner_d;
    logic [15:0] number_q, number_d;
    logic [15:0] cnt_q, cnt_d;
    logic        disp_en_q, disp_en_d;

    logic        at_lim;
    logic [1:0]  start;
    logic [3:0]  contend;
    logic        take, go_idle;
    logic [1:0]  win;

    // First set bit of m, scanning upward from start with wrap-around.
    function automatic logic [1:0] pick(input logic [3:0] m, input logic [1:0] st);
        logic [1:0] w;
        logic [1:0] idx;
        logic       found;
        w     = st;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = st + 2'(k);
            if (!found && m[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [15:0] sel(input logic [63:0] d, input logic [1:0] i);
        return d[{i, 4'b0000} +: 16];
    endfunction

    assign at_lim = (cnt_q == DWELL);

`ifdef SEG_ARB_ROUNDROBIN_EN
    assign start   = owner_q + 2'd1;
    assign contend = req & ~(4'b0001 << owner_q);
`else
    assign start   = 2'd0;
    assign contend = req & ((4'b0001 << owner_q) - 4'b0001);
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        number_d  = number_q;
        cnt_d     = at_lim ? cnt_q : cnt_q + 16'd1;
        take      = 1'b0;
        go_idle   = 1'b0;
        win       = owner_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|req) begin
                    take = 1'b1;
                    win  = pick(req, start);
                end
            end
            SHOW: begin
                if (req[owner_q]) begin
                    if (at_lim && |contend) begin
                        take = 1'b1;
                        win  = pick(contend, start);
                    end else begin
                        number_d = sel(data, owner_q);
                    end
                end else if (!at_lim) begin
                    state_d = HOLD;
                end else if (|req) begin
                    take = 1'b1;
                    win  = pick(req, start);
                end else begin
                    go_idle = 1'b1;
                end
            end
            HOLD: begin
                // Owner re-asserting here does not resume early; only dwell expiry re-arbitrates.
                if (at_lim) begin
                    if (|req) begin
                        take = 1'b1;
                        win  = pick(req, start);
                    end else begin
                        go_idle = 1'b1;
                    end
                end
            end
            default: go_idle = 1'b1;
        endcase
        if (take) begin
            state_d  = SHOW;
            grant_d  = 4'b0001 << win;
            owner_d  = win;
            cnt_d    = '0;
            number_d = sel(data, win);
        end
        if (go_idle) begin
            state_d  = IDLE;
            grant_d  = '0;
            cnt_d    = '0;
            number_d = '0;
        end
        disp_en_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= 2'd3;
            number_q  <= '0;
            cnt_q     <= '0;
            disp_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            number_q  <= number_d;
            cnt_q     <= cnt_d;
            disp_en_q <= disp_en_d;
        end
    end

    assign grant    = grant_q;
    assign owner_id = owner_q;
    assign number   = number_q;
    assign disp_en  = disp_en_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter (DWELL_CYCLES=4): directed scenarios then random traffic
// compared against a cycle-level ownership model.
module tb_seg_display_arbiter;

    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  grant;
    logic [1:0]  owner_id;
    logic [15:0] number;
    logic        disp_en;

    int total = 0;
    int bad   = 0;

    // Model: who owns the display, whether they've let go, how long they've had it.
    bit          m_on;
    bit          m_hold;
    int          m_own;
    int          m_cnt;
    logic [15:0] m_num;

    seg_display_arbiter #(.DWELL_CYCLES(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data),
        .grant(grant), .owner_id(owner_id), .number(number), .disp_en(disp_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] slot(input logic [63:0] d, input int i);
        return 16'(d >> (16 * i));
    endfunction

    // Scan candidates starting at s, wrapping; -1 when nobody qualifies.
    function automatic int first_from(input logic [3:0] cand, input int s);
        for (int k = 0; k < 4; k++)
            if (cand[(s + k) % 4]) return (s + k) % 4;
        return -1;
    endfunction

    function automatic int search_start();
`ifdef SEG_ARB_ROUNDROBIN_EN
        return (m_own + 1) % 4;
`else
        return 0;
`endif
    endfunction

    function automatic logic [3:0] rivals(input logic [3:0] r);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 4; i++) begin
`ifdef SEG_ARB_ROUNDROBIN_EN
            if (i != m_own) c[i] = r[i];
`else
            if (i < m_own) c[i] = r[i];
`endif
        end
        return c;
    endfunction

    task automatic give_to(input int w);
        m_on = 1; m_hold = 0; m_own = w; m_cnt = 0; m_num = slot(data, w);
    endtask

    task automatic go_dark();
        m_on = 0; m_hold = 0; m_cnt = 0; m_num = '0;
    endtask

    task automatic model_edge();
        int w;
        bool_dummy();
        if (!rst) begin
            go_dark();
            m_own = 3;
        end else if (!m_on) begin
            w = first_from(req, search_start());
            if (w >= 0) give_to(w);
        end else if (!m_hold && req[m_own]) begin
            w = first_from(rivals(req), search_start());
            if (m_cnt == DW && w >= 0) give_to(w);
            else begin
                m_num = slot(data, m_own);
                if (m_cnt < DW) m_cnt++;
            end
        end else if (m_cnt < DW) begin
            m_hold = 1;
            m_cnt++;
        end else begin
            w = first_from(req, search_start());
            if (w >= 0) give_to(w);
            else go_dark();
        end
    endtask

    function automatic void bool_dummy();
    endfunction

    task automatic step(input logic r, input logic [3:0] rq, input logic [63:0] d);
        logic [3:0] eg;
        rst = r; req = rq; data = d;
        model_edge();
        @(posedge clk);
        #1;
        eg = m_on ? 4'(1 << m_own) : 4'b0000;
        chk("grant", 16'(grant), 16'(eg));
        chk("owner_id", 16'(owner_id), 16'(m_own));
        chk("number", number, m_num);
        chk("disp_en", 16'(disp_en), 16'(m_on));
        chk("onehot", 16'($countones(grant) <= 1), 16'd1);
    endtask

    initial begin
        logic [63:0] d;
        logic [3:0]  r;
        m_on = 0; m_hold = 0; m_own = 3; m_cnt = 0; m_num = '0;
        rst = 1'b0; req = '0; data = '0;

        // Reset state
        step(1'b0, 4'b0000, 64'h0);
        chk("rst_owner", 16'(owner_id), 16'd3);
        chk("rst_grant", 16'(grant), 16'd0);

        // Single request on source 2
        d = 64'h0000_1234_0000_0000;
        step(1'b1, 4'b0100, d);
        chk("req025_grant", 16'(grant), 16'h0004);
        chk("req025_owner", 16'(owner_id), 16'd2);
        chk("req025_num", number, 16'h1234);
        chk("req025_en", 16'(disp_en), 16'd1);

        // Mid-SHOW reset
        step(1'b1, 4'b0100, d);
        step(1'b0, 4'b0100, d);
        chk("req029_owner", 16'(owner_id), 16'd3);
        chk("req029_num", number, 16'h0000);
        chk("req029_en", 16'(disp_en), 16'd0);

        // Data tracking with one-cycle latency
        d = 64'h0001;
        step(1'b1, 4'b0001, d);
        chk("req030_a", number, 16'h0001);
        d = 64'h0002;
        step(1'b1, 4'b0001, d);
        chk("req030_b", number, 16'h0002);

        // Release before dwell: hold frozen, then idle
        step(1'b0, 4'b0000, 64'h0);
        d = 64'h0005;
        step(1'b1, 4'b0001, d);
        d = 64'h9999;
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, d);
        chk("req026_held", 16'(grant), 16'h0001);
        chk("req026_frozen", number, 16'h0005);
        step(1'b1, 4'b0000, d);
        chk("req026_idle", 16'(grant), 16'h0000);
        chk("req026_num0", number, 16'h0000);

        // Owner 2 with other requests arriving
        step(1'b0, 4'b0000, 64'h0);
        d = 64'h4444_3333_2222_1111;
        step(1'b1, 4'b0100, d);
        for (int i = 0; i < 8; i++) step(1'b1, 4'b1100, d);
`ifndef SEG_ARB_ROUNDROBIN_EN
        chk("req028_nopre", 16'(owner_id), 16'd2);
`endif
        step(1'b1, 4'b0101, d);
`ifndef SEG_ARB_ROUNDROBIN_EN
        chk("req028_pre", 16'(owner_id), 16'd0);
`endif
        for (int i = 0; i < 12; i++) step(1'b1, 4'b1011, d);

        // Random traffic
        r = '0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(3) == 0) r = 4'($urandom);
            d = {$urandom, $urandom};
            step(($urandom_range(63) != 0), r, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 1000, minimum clk cycles a granted source owns the display (legal 1..65535).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req  input  4  per-source display request, level-sensitive.
REQ-005 SHALL have port data  input  64  per-source 4-digit BCD value; source i at bits [16i+15:16i].
REQ-006 SHALL have port grant  output  4  one-hot owner indication, all-zero when idle.
REQ-007 SHALL have port owner_id  output  2  index of current or most recent owner.
REQ-008 SHALL have port number  output  16  BCD value fed to the display driver's number input.
REQ-009 SHALL have port disp_en  output  1  high while a source owns the display.

Function
REQ-010 SHALL implement states IDLE, SHOW, HOLD; all outputs registered.
REQ-011 IDLE: req==0 -> stay; else next cycle SHOW, grant/owner_id = winner, dwell counter = 0, number = data of winner sampled at that edge.
REQ-012 SHOW: number SHALL track data[owner] with 1-cycle latency; dwell counter increments each cycle, saturating at DWELL_CYCLES.
REQ-013 SHOW, req[owner]=0, counter<DWELL_CYCLES -> HOLD; grant kept, number frozen at last value.
REQ-014 SHOW, req[owner]=0, counter=DWELL_CYCLES -> arbitrate: a winner exists -> SHOW with new owner, counter=0, no idle cycle; none -> IDLE.
REQ-015 SHOW, req[owner]=1, counter=DWELL_CYCLES, another eligible requester pending -> switch to it directly (preemption); otherwise owner retained indefinitely.
REQ-016 HOLD: counter increments; on reaching DWELL_CYCLES -> arbitrate as REQ-014 (previous owner eligible); owner re-asserting req in HOLD does not resume SHOW early.
REQ-017 IDLE outputs: grant=4'b0000, disp_en=0, number=16'h0000; owner_id retains last owner.
REQ-018 disp_en SHALL equal |grant every cycle; grant never has more than one bit set.
REQ-019 DWELL_CYCLES=1: counter reaches limit one cycle after grant; preemption/release legal from the second SHOW cycle.
REQ-020 data is passed through unmodified; no BCD validity check.

Reset
REQ-021 rst=0 at a clock edge SHALL force IDLE, grant=0, disp_en=0, number=16'h0000, owner_id=2'd3, counter=0, regardless of state (including mid-SHOW/HOLD).
REQ-022 First cycle after rst release SHALL behave as IDLE with req sampled normally.

Configuration
REQ-023 Macro SEG_ARB_ROUNDROBIN_EN defined: winner = first requester searching from owner_id+1 modulo 4 (after reset, from 0); any other requester may preempt per REQ-015.
REQ-024 Macro undefined: fixed priority, lowest index wins; preemption per REQ-015 only by a requester with index lower than owner.

Verification (DWELL_CYCLES=4)
REQ-025 Reset then req=4'b0100, data[47:32]=16'h1234 -> one cycle later grant=4'b0100, owner_id=2, disp_en=1, number=16'h1234.
REQ-026 Owner 0 granted, req drops after 1 cycle -> HOLD, number frozen, grant held until counter=4, then IDLE, number=16'h0000.
REQ-027 RR build: owner 1 holding, req=4'b1011 at counter=4 -> next owner 3, then 0, then 1, each held 4 cycles.
REQ-028 Fixed-priority build: owner 2 holding, req[3] asserted -> no preemption; req[0] asserted -> owner 0 after dwell.
REQ-029 rst=0 asserted mid-SHOW -> next cycle all outputs at reset values, owner_id=3.
REQ-030 Owner 0 data changes 16'h0001->16'h0002 during SHOW -> number updates exactly one cycle later.
